// File: rtl/alu_wide_sequencer.sv
// alu_wide_sequencer: runs one (16*WORDS)-bit operation on an external 16-bit ALU,
// one limb per cycle, chaining the ALU carry between limbs. It assembles the wide
// result and the flags {CF, ZF, NF, VF, PF}.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start, op, opa, opb   request (accepted in IDLE only), opcode, wide operands
//   busy, done            busy during RUN; done is a one-cycle completion pulse
//   result, flags         wide result and flags, held until the next completion
//   alu_A/B/F/Cin         registered drive to the ALU
//   alu_Result/Status     combinational ALU response, sampled on each RUN edge
module alu_wide_sequencer #(
  parameter int unsigned WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [16*WORDS-1:0]   opa,
  input  logic [16*WORDS-1:0]   opb,
  output logic                  busy,
  output logic                  done,
  output logic [16*WORDS-1:0]   result,
  output logic [4:0]            flags,
  output logic [15:0]           alu_A,
  output logic [15:0]           alu_B,
  output logic [4:0]            alu_F,
  output logic                  alu_Cin,
  input  logic [15:0]           alu_Result,
  input  logic [5:0]            alu_Status
);

  localparam int unsigned W     = 16 * WORDS;
  localparam int unsigned IDX_W = $clog2(WORDS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_SAR = 3'b111;

  localparam logic [4:0] F_ADD = 5'b00100;
  localparam logic [4:0] F_ADC = 5'b00101;
  localparam logic [4:0] F_SUB = 5'b00110;
  localparam logic [4:0] F_SBB = 5'b00111;
  localparam logic [4:0] F_AND = 5'b01000;
  localparam logic [4:0] F_OR  = 5'b01001;
  localparam logic [4:0] F_XOR = 5'b01010;
  localparam logic [4:0] F_RCL = 5'b10110;
  localparam logic [4:0] F_RCR = 5'b10111;

  // ALU opcode for the first limb of an operation
  function automatic logic [4:0] first_f(input logic [2:0] o);
    case (o)
      OP_ADD:  return F_ADD;
      OP_SUB:  return F_SUB;
      OP_AND:  return F_AND;
      OP_OR:   return F_OR;
      OP_XOR:  return F_XOR;
      OP_SHL:  return F_RCL;
      default: return F_RCR;
    endcase
  endfunction

  // ALU opcode for the remaining limbs (carry-chained forms for ADD/SUB)
  function automatic logic [4:0] rest_f(input logic [2:0] o);
    case (o)
      OP_ADD:  return F_ADC;
      OP_SUB:  return F_SBB;
      default: return first_f(o);
    endcase
  endfunction

  function automatic logic is_logic(input logic [2:0] o);
    return (o == OP_AND) || (o == OP_OR) || (o == OP_XOR);
  endfunction

  function automatic logic is_shift(input logic [2:0] o);
    return (o == OP_SHL) || (o == OP_SHR) || (o == OP_SAR);
  endfunction

  // Right shifts walk limbs from high to low so the carry moves downward
  function automatic logic is_down(input logic [2:0] o);
    return (o == OP_SHR) || (o == OP_SAR);
  endfunction

  logic [1:0]             state_q, state_d;
  logic [WORDS-1:0][15:0] opa_l, opb_l;
  logic [WORDS-1:0][15:0] a_q, a_d, b_q, b_d, acc_q, acc_d, last_res;
  logic [2:0]             op_q, op_d;
  logic [IDX_W-1:0]       idx_q, idx_d, cnt_q, cnt_d, start_idx, next_idx;
  logic                   busy_d, done_d, cf_fin, vf_fin;
  logic [W-1:0]           result_d;
  logic [4:0]             flags_d;
  logic [15:0]            alu_A_d, alu_B_d;
  logic [4:0]             alu_F_d;
  logic                   alu_Cin_d;
  logic                   unused_status;

  assign opa_l = opa;
  assign opb_l = opb;

  // Only CF and VF of the ALU status are consumed
  assign unused_status = ^{alu_Status[4:3], alu_Status[1:0]};

  // Next-state and registered-output computation
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    result_d  = result;
    flags_d   = flags;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    alu_A_d   = 16'h0000;
    alu_B_d   = 16'h0000;
    alu_F_d   = 5'b00000;
    alu_Cin_d = 1'b0;

    start_idx = is_down(op) ? IDX_W'(WORDS - 1) : '0;
    next_idx  = is_down(op_q) ? (idx_q - IDX_W'(1)) : (idx_q + IDX_W'(1));
    last_res  = acc_q;
    last_res[idx_q] = alu_Result;
    cf_fin    = is_logic(op_q) ? 1'b0 : alu_Status[5];
    vf_fin    = ((op_q == OP_ADD) || (op_q == OP_SUB)) ? alu_Status[2] : 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d       = opa_l;
          b_d       = opb_l;
          op_d      = op;
          idx_d     = start_idx;
          cnt_d     = '0;
          acc_d     = '0;
          alu_A_d   = opa_l[start_idx];
          alu_B_d   = is_shift(op) ? 16'h0000 : opb_l[start_idx];
          alu_F_d   = first_f(op);
          alu_Cin_d = (op == OP_SAR) ? opa_l[WORDS-1][15] : 1'b0;
          busy_d    = 1'b1;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = last_res;
        if (cnt_q == IDX_W'(WORDS - 1)) begin
          result_d = last_res;
          flags_d  = {cf_fin, ~|last_res, last_res[WORDS-1][15], vf_fin, ~^last_res};
          done_d   = 1'b1;
          state_d  = S_DONE;
        end else begin
          idx_d     = next_idx;
          cnt_d     = cnt_q + IDX_W'(1);
          alu_A_d   = a_q[next_idx];
          alu_B_d   = is_shift(op_q) ? 16'h0000 : b_q[next_idx];
          alu_F_d   = rest_f(op_q);
          alu_Cin_d = is_logic(op_q) ? 1'b0 : alu_Status[5];
          busy_d    = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 3'b000;
      idx_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      flags   <= 5'b00000;
      alu_A   <= 16'h0000;
      alu_B   <= 16'h0000;
      alu_F   <= 5'b00000;
      alu_Cin <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      busy    <= busy_d;
      done    <= done_d;
      result  <= result_d;
      flags   <= flags_d;
      alu_A   <= alu_A_d;
      alu_B   <= alu_B_d;
      alu_F   <= alu_F_d;
      alu_Cin <= alu_Cin_d;
    end
  end

endmodule

// File: doc/alu_wide_sequencer.md
# alu_wide_sequencer

Multi-cycle controller that drives the 16-bit ALU from the operand side and consumes its `Result`/`Status`. It executes one (16·WORDS)-bit operation by issuing one ALU opcode per 16-bit limb, chaining the ALU carry flag into `Cin` between limbs. It assembles the wide result and wide flags, then reports completion over a start/done handshake.

## Interface
- WORDS, 4, number of 16-bit limbs; operand width W = 16·WORDS; legal range 2..8.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted only in IDLE.
- op  in  3  operation: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL1, 110 SHR1 (logical), 111 SAR1.
- opa  in  W  first operand; sampled on accept.
- opb  in  W  second operand; sampled on accept; ignored for shifts.
- busy  out  1  high from the cycle after accept until done.
- done  out  1  one-cycle pulse when result/flags become valid.
- result  out  W  wide result; held until the next accept.
- flags  out  5  {CF, ZF, NF, VF, PF}; held with result.
- alu_A  out  16  limb of operand A to the ALU.
- alu_B  out  16  limb of operand B to the ALU.
- alu_F  out  5  ALU opcode.
- alu_Cin  out  1  ALU carry input.
- alu_Result  in  16  ALU result; combinational from alu_* outputs.
- alu_Status  in  6  ALU flags {CF, ZF, NF, VF, PF, AF}; only CF (bit 5) and VF (bit 2) are used.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on start: latch opa, opb, op; idx ← start limb; carry ← initial carry.
  - RUN: one limb per cycle. Write alu_Result into the result limb, carry ← alu_Status[5], step idx. After WORDS limbs, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Limb order and opcodes:
  - ADD: limb 0 → WORDS-1. First limb F=00100; remaining limbs F=00101 with Cin=carry.
  - SUB: limb 0 → WORDS-1. First limb F=00110; remaining limbs F=00111 with Cin=carry (CF=1 means borrow).
  - AND/OR/XOR: any order (low → high is required for verification determinism). F=01000/01001/01010; Cin=0.
  - SHL1: low → high, F=10110 (RCL); first Cin=0, then Cin=carry.
  - SHR1: high → low, F=10111 (RCR); first Cin=0, then Cin=carry.
  - SAR1: high → low, F=10111; first Cin=opa[W-1], then Cin=carry.
- In IDLE and DONE: alu_A=alu_B=0, alu_F=00000, alu_Cin=0.
- Flags, all computed by the sequencer over the wide result:
  - CF: ADD/SUB/shifts use the ALU CF of the last limb issued. Logic ops force CF=0, because the ALU does not define CF for them.
  - ZF = (result == 0).
  - NF = result[W-1].
  - VF: ADD/SUB use the ALU VF of limb WORDS-1. All other ops force VF=0.
  - PF = XNOR-reduce of the whole W-bit result.
- start while busy or in DONE is ignored; no queueing.
- opa/opb changes after accept have no effect.

## Timing
- Accept in cycle 0 (IDLE, start=1).
- RUN occupies cycles 1..WORDS.
- done=1 and result/flags valid in cycle WORDS+1; latency is WORDS+1 cycles.
- Minimum start-to-start interval is WORDS+2 cycles.
- The ALU path is combinational within a RUN cycle: alu_* outputs are driven from registers, and alu_Result/alu_Status are sampled at the same clock edge.
- Reset values: busy=0, done=0, result=0, flags=0, alu_A=0, alu_B=0, alu_F=0, alu_Cin=0, state IDLE.
- Reset asserted mid-RUN aborts immediately. No done is issued, and result/flags clear to 0.
- start held high continuously re-triggers one operation every WORDS+2 cycles.

## Test plan
- ADD, WORDS=4, opa=0x0000_0000_FFFF_FFFF, opb=1 → result 0x0000_0001_0000_0000, CF=0, ZF=0, VF=0. done exactly at cycle 5 after accept.
- ADD opa=0xFFFF_FFFF_FFFF_FFFF, opb=1 → result 0, CF=1, ZF=1, NF=0, VF=0, PF=1. Then ADD opa=0x7FFF_FFFF_FFFF_FFFF, opb=1 → 0x8000_0000_0000_0000, VF=1, NF=1.
- SUB opa=0, opb=1 → 0xFFFF_FFFF_FFFF_FFFF, CF=1, NF=1, VF=0, PF=1. Check that alu_F is 00110 then 00111 ×3.
- SAR1 opa=0x8000_0000_0000_0001 → 0xC000_0000_0000_0000, CF=1, NF=1. SHL1 opa=0x0000_8000_0000_8000 → 0x0001_0000_0001_0000, CF=0.
- XOR opa=0x1234_5678_9ABC_DEF0, opb=same → result 0, ZF=1, CF=0, VF=0. A second start pulse issued in cycle 2 is ignored: exactly one done.
- Start ADD, assert rst_n=0 in cycle 2 → busy/done/result/flags/alu_* = 0 immediately. After release, a new ADD 1+1 → 2 with correct latency.
